pass_check: RTL and testbench
=============================

PASS_CHECK -- requirements
Module: pass_check

Interface
REQ-001 Parameter MAX_TRIES, default 3: consecutive failed attempts that trigger lockout (legal range 1..3).
REQ-002 Parameter LOCK_CYCLES, default 100_000_000: lockout duration in CLK cycles (1 s at 100 MHz); minimum 1.
REQ-003 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 D  input  3  switch value for the digit being entered.
REQ-006 EN  input  1  enter button level; a press is EN=1 on a cycle where EN was 0 the previous cycle.
REQ-007 create  input  1  create mode; 1 = password being written, checker suspended.
REQ-008 PW1, PW2, PW3  input  3 each  stored password digits 1..3, held by the password registers.
REQ-009 stage  output  2  digit awaited: 1, 2, 3 in entry states; 0 in OPEN and LOCKED.
REQ-010 unlock  output  1  box open.
REQ-011 fail  output  1  one-cycle pulse on a wrong 3-digit attempt.
REQ-012 lockout  output  1  high while LOCKED.
REQ-013 attempts  output  2  count of consecutive failed attempts.

Function
REQ-014 All outputs are registered; states are S1, S2, S3, OPEN, LOCKED.
REQ-015 Press detect: en_q register holds previous EN; press = EN & ~en_q; en_q updates every cycle, including in LOCKED and while create=1.
REQ-016 S1 press: match <= (D==PW1), go to S2.
REQ-017 S2 press: match <= match & (D==PW2), go to S3.
REQ-018 S3 press, all three digits equal: go to OPEN, attempts <= 0.
REQ-019 S3 press, any mismatch: fail=1 for exactly the next cycle, attempts <= attempts+1.
REQ-020 After REQ-019, if new attempts == MAX_TRIES: go to LOCKED, load timer with LOCK_CYCLES-1; otherwise go to S1.
REQ-021 No mismatch indication before the third digit; stage advances identically for right and wrong digits.
REQ-022 Comparisons use PW values present on the press cycle.
REQ-023 OPEN: unlock=1; a press relocks: go to S1, unlock <= 0, attempts unchanged (already 0).
REQ-024 create=1 in S1/S2/S3: go to S1, match <= 1, presses ignored, attempts unchanged.
REQ-025 create=1 in OPEN: stay in OPEN, presses ignored; password change is only meaningful while open.
REQ-026 LOCKED: presses and create ignored; timer decrements by 1 each cycle; on the cycle timer==0, go to S1, attempts <= 0, lockout <= 0.
REQ-027 LOCK_CYCLES=1: LOCKED lasts exactly one cycle.
REQ-028 attempts never exceeds MAX_TRIES and never wraps.
REQ-029 EN held high: exactly one press per rising edge, regardless of duration.
REQ-030 Timer width is ceil(log2(LOCK_CYCLES))+1 bits minimum; no overflow at default.

Reset
REQ-031 RST=1 at posedge CLK: state=S1, stage=1, match=1, attempts=0, timer=0, unlock=0, fail=0, lockout=0.
REQ-032 en_q resets to 1, so EN held through reset release produces no press until EN falls and rises again.
REQ-033 RST has priority over every event, including mid-attempt, OPEN and LOCKED; lockout is abandoned immediately.

Verification
REQ-034 PW=5,2,7; press D=5,2,7 -> stage 1->2->3->0; unlock=1 the cycle after the third press; attempts=0.
REQ-035 PW=5,2,7; enter 5,3,7 -> stage still walks 1,2,3; fail pulses one cycle; attempts=1; stage=1; unlock=0.
REQ-036 MAX_TRIES=3, LOCK_CYCLES=8; three wrong attempts -> lockout=1 for exactly 8 cycles; presses ignored during lockout; then stage=1, attempts=0.
REQ-037 In S2, raise create for 2 cycles with presses -> stage returns to 1, no advance; a full correct entry afterwards opens.
REQ-038 OPEN, create=1, PW changes to 1,1,1, create=0, press -> stage=1; entry 1,1,1 opens; old code fails.
REQ-039 EN held high across RST deassertion -> no stage change until EN toggles 0->1; RST asserted in LOCKED -> lockout=0, stage=1 next cycle.

Source files
------------

// File: rtl/pass_check.sv
// pass_check: three-digit combination lock with retry lockout.
// Digits are entered on rising edges of EN; after MAX_TRIES consecutive
// wrong attempts the lock ignores all input for LOCK_CYCLES cycles.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   D                 digit switches
//   EN                enter button level (rising edge = press)
//   create            password being written; checker suspended
//   PW1..PW3          stored password digits
//   stage             digit awaited (1..3), 0 when open or locked
//   unlock            box open
//   fail              one-cycle pulse after a wrong 3-digit attempt
//   lockout           high while locked out
//   attempts          consecutive failed attempts
module pass_check #(
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCK_CYCLES = 100_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] D,
  input  logic       EN,
  input  logic       create,
  input  logic [2:0] PW1,
  input  logic [2:0] PW2,
  input  logic [2:0] PW3,
  output logic [1:0] stage,
  output logic       unlock,
  output logic       fail,
  output logic       lockout,
  output logic [1:0] attempts
);

  localparam int unsigned TW = $clog2(LOCK_CYCLES) + 1;

  typedef enum logic [2:0] {
    S1     = 3'd0,
    S2     = 3'd1,
    S3     = 3'd2,
    OPEN   = 3'd3,
    LOCKED = 3'd4
  } state_t;

  state_t          state, state_d;
  logic            en_q;
  logic            press;
  logic            match, match_d;
  logic [1:0]      attempts_d;
  logic [TW-1:0]   timer, timer_d;
  logic            fail_d;
  logic [1:0]      stage_d;

  assign press = EN & ~en_q;

  // State and output registers; outputs follow the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S1;
      en_q     <= 1'b1;
      match    <= 1'b1;
      attempts <= 2'd0;
      timer    <= '0;
      stage    <= 2'd1;
      unlock   <= 1'b0;
      fail     <= 1'b0;
      lockout  <= 1'b0;
    end else begin
      state    <= state_d;
      en_q     <= EN;
      match    <= match_d;
      attempts <= attempts_d;
      timer    <= timer_d;
      stage    <= stage_d;
      unlock   <= (state_d == OPEN);
      fail     <= fail_d;
      lockout  <= (state_d == LOCKED);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    match_d    = match;
    attempts_d = attempts;
    timer_d    = timer;
    fail_d     = 1'b0;

    case (state)
      S1: begin
        if (create) begin
          match_d = 1'b1;
        end else if (press) begin
          match_d = (D == PW1);
          state_d = S2;
        end
      end
      S2: begin
        if (create) begin
          state_d = S1;
          match_d = 1'b1;
        end else if (press) begin
          match_d = match & (D == PW2);
          state_d = S3;
        end
      end
      S3: begin
        if (create) begin
          state_d = S1;
          match_d = 1'b1;
        end else if (press) begin
          if (match && (D == PW3)) begin
            state_d    = OPEN;
            attempts_d = 2'd0;
          end else begin
            fail_d = 1'b1;
            // Saturate so the count can never wrap past MAX_TRIES.
            if (attempts != 2'(MAX_TRIES)) begin
              attempts_d = 2'(attempts + 2'd1);
            end
            if (attempts_d == 2'(MAX_TRIES)) begin
              state_d = LOCKED;
              timer_d = TW'(LOCK_CYCLES - 1);
            end else begin
              state_d = S1;
            end
          end
        end
      end
      OPEN: begin
        if (!create && press) begin
          state_d = S1;
        end
      end
      LOCKED: begin
        if (timer == '0) begin
          state_d    = S1;
          attempts_d = 2'd0;
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      default: begin
        state_d = S1;
        match_d = 1'b1;
      end
    endcase

    case (state_d)
      S1:      stage_d = 2'd1;
      S2:      stage_d = 2'd2;
      S3:      stage_d = 2'd3;
      default: stage_d = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pass_check.sv
// Self-checking bench for pass_check (MAX_TRIES=3, LOCK_CYCLES=8).
module tb_pass_check;

  localparam int MAX_T  = 3;
  localparam int LOCK_C = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] D;
  logic       EN;
  logic       create;
  logic [2:0] PW1, PW2, PW3;
  logic [1:0] stage;
  logic       unlock;
  logic       fail;
  logic       lockout;
  logic [1:0] attempts;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  pass_check #(
    .MAX_TRIES  (MAX_T),
    .LOCK_CYCLES(LOCK_C)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .D       (D),
    .EN      (EN),
    .create  (create),
    .PW1     (PW1),
    .PW2     (PW2),
    .PW3     (PW3),
    .stage   (stage),
    .unlock  (unlock),
    .fail    (fail),
    .lockout (lockout),
    .attempts(attempts)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: digits entered so far, open flag, lockout countdown.
  bit   m_valid   = 1'b0;
  bit   m_prev_en = 1'b1;
  int   m_digits  = 0;
  bit   m_ok      = 1'b1;
  bit   m_open    = 1'b0;
  int   m_lock    = 0;
  int   m_tries   = 0;
  bit   m_fail    = 1'b0;
  int   fail_seen = 0;
  int   lock_seen = 0;

  task automatic model_step();
    bit         pr;
    logic [2:0] pw;
    pr = EN && !m_prev_en;
    if (RST) begin
      m_valid  = 1'b1;
      m_digits = 0;
      m_ok     = 1'b1;
      m_open   = 1'b0;
      m_lock   = 0;
      m_tries  = 0;
      m_fail   = 1'b0;
    end else begin
      m_fail = 1'b0;
      if (m_lock > 0) begin
        m_lock--;
        if (m_lock == 0) m_tries = 0;
      end else if (m_open) begin
        if (pr && !create) m_open = 1'b0;
      end else if (create) begin
        m_digits = 0;
        m_ok     = 1'b1;
      end else if (pr) begin
        pw = (m_digits == 0) ? PW1 : (m_digits == 1) ? PW2 : PW3;
        m_ok = m_ok && (D == pw);
        m_digits++;
        if (m_digits == 3) begin
          if (m_ok) begin
            m_open  = 1'b1;
            m_tries = 0;
          end else begin
            m_fail = 1'b1;
            if (m_tries < MAX_T) m_tries++;
            if (m_tries == MAX_T) m_lock = LOCK_C;
          end
          m_digits = 0;
          m_ok     = 1'b1;
        end
      end
    end
    m_prev_en = RST ? 1'b1 : EN;
  endtask

  always @(posedge CLK) model_step();

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (m_valid) begin
      chk("stage",    32'(stage),    (m_open || m_lock > 0) ? 32'd0 : 32'(m_digits + 1));
      chk("unlock",   32'(unlock),   32'(m_open));
      chk("fail",     32'(fail),     32'(m_fail));
      chk("lockout",  32'(lockout),  32'(m_lock > 0));
      chk("attempts", 32'(attempts), 32'(m_tries));
      if (fail === 1'b1) fail_seen++;
      if (lockout === 1'b1) lock_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input logic [2:0] d);
    D  = d;
    EN = 1'b1;
    tick(1);
    EN = 1'b0;
    tick(1);
  endtask

  task automatic enter3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    press(a);
    press(b);
    press(c);
  endtask

  int f0;
  int l0;
  int k;

  initial begin
    RST = 1'b1; EN = 1'b0; D = 3'd0; create = 1'b0;
    PW1 = 3'd5; PW2 = 3'd2; PW3 = 3'd7;
    tick(2);
    chk("rst_stage",    32'(stage),    32'd1);
    chk("rst_attempts", 32'(attempts), 32'd0);
    chk("rst_unlock",   32'(unlock),   32'd0);
    chk("rst_lockout",  32'(lockout),  32'd0);
    RST = 1'b0;
    tick(1);

    // Correct entry walks the stages and opens.
    press(3'd5); chk("ok_stage2", 32'(stage), 32'd2);
    press(3'd2); chk("ok_stage3", 32'(stage), 32'd3);
    press(3'd7);
    chk("ok_stage0", 32'(stage),    32'd0);
    chk("ok_unlock", 32'(unlock),   32'd1);
    chk("ok_att",    32'(attempts), 32'd0);
    press(3'd0);
    chk("relock_stage",  32'(stage),  32'd1);
    chk("relock_unlock", 32'(unlock), 32'd0);

    // Wrong middle digit: no early indication, single fail pulse.
    f0 = fail_seen;
    press(3'd5);
    press(3'd3); chk("bad_stage3", 32'(stage), 32'd3);
    press(3'd7);
    chk("bad_fail_pulse", 32'(fail_seen - f0), 32'd1);
    chk("bad_att",        32'(attempts),       32'd1);
    chk("bad_stage1",     32'(stage),          32'd1);
    chk("bad_unlock",     32'(unlock),         32'd0);
    enter3(3'd5, 3'd2, 3'd7);
    chk("reopen_att", 32'(attempts), 32'd0);
    press(3'd1);

    // Three wrong attempts lock out for exactly LOCK_C cycles.
    enter3(3'd1, 3'd1, 3'd1);
    enter3(3'd1, 3'd1, 3'd1);
    l0 = lock_seen;
    enter3(3'd1, 3'd1, 3'd1);
    chk("lock_on",  32'(lockout),  32'd1);
    chk("lock_att", 32'(attempts), 32'd3);
    enter3(3'd5, 3'd2, 3'd7);
    k = 0;
    while (lockout === 1'b1 && k < 50) begin
      tick(1);
      k++;
    end
    chk("lock_bounded", 32'(k < 50),           32'd1);
    chk("lock_length",  32'(lock_seen - l0),   32'd8);
    chk("unlock_stage", 32'(stage),            32'd1);
    chk("unlock_att",   32'(attempts),         32'd0);

    // create in S2 with presses aborts the entry.
    press(3'd5);
    chk("c_stage2", 32'(stage), 32'd2);
    create = 1'b1; D = 3'd2; EN = 1'b1;
    tick(1);
    EN = 1'b0;
    tick(1);
    create = 1'b0;
    chk("c_stage1", 32'(stage), 32'd1);
    enter3(3'd5, 3'd2, 3'd7);
    chk("c_open", 32'(unlock), 32'd1);

    // Password change while open.
    create = 1'b1;
    PW1 = 3'd1; PW2 = 3'd1; PW3 = 3'd1;
    press(3'd3);
    chk("pw_open_hold", 32'(unlock), 32'd1);
    create = 1'b0;
    press(3'd0);
    chk("pw_stage1", 32'(stage),  32'd1);
    chk("pw_closed", 32'(unlock), 32'd0);
    enter3(3'd1, 3'd1, 3'd1);
    chk("pw_new_open", 32'(unlock), 32'd1);
    press(3'd0);
    enter3(3'd5, 3'd2, 3'd7);
    chk("pw_old_fail", 32'(attempts), 32'd1);
    chk("pw_old_shut", 32'(unlock),   32'd0);

    // EN held through reset release gives no press.
    EN = 1'b1; RST = 1'b1;
    tick(2);
    RST = 1'b0;
    tick(3);
    chk("en_hold_stage", 32'(stage), 32'd1);
    EN = 1'b0; tick(1);
    EN = 1'b1; tick(1);
    chk("en_edge_stage", 32'(stage), 32'd2);
    EN = 1'b0; tick(1);
    press(3'd0);
    press(3'd0);
    chk("en_att1", 32'(attempts), 32'd1);

    // Reset during lockout abandons it immediately.
    enter3(3'd0, 3'd0, 3'd0);
    enter3(3'd0, 3'd0, 3'd0);
    chk("rl_locked", 32'(lockout), 32'd1);
    tick(2);
    RST = 1'b1;
    tick(1);
    chk("rl_lockout", 32'(lockout), 32'd0);
    chk("rl_stage",   32'(stage),   32'd1);
    RST = 1'b0;
    tick(2);
    enter3(3'd1, 3'd1, 3'd1);
    chk("rl_open", 32'(unlock), 32'd1);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
